// File: rtl/glb_pkg.sv
// Shared GLB bank constants and the arbiter selection type used by the bank
// memory controller.
package glb_pkg;

    localparam int BANK_DATA_WIDTH      = 64;
    localparam int BANK_ADDR_WIDTH      = 14;
    localparam int BANK_BYTE_OFFSET     = 3;
    localparam int BANK_SRAM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_READ  = 2'd2
    } arb_sel_e;

endpackage

// File: rtl/glb_valid_pipe.sv
// Fixed-depth valid shift register; bit k is high k+1 cycles after valid_in.
module glb_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    output logic [DEPTH-1:0] valid_pipe
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[DEPTH-2:0], valid_in};
        end
    end

endmodule

// File: rtl/glb_bank_mem_ctrl.sv
// GLB bank request controller: arbitrates byte-strobed writes and reads onto
// the single glb_bank_sram_gen port and returns read data at a fixed latency.
module glb_bank_mem_ctrl
    import glb_pkg::*;
#(
    parameter int DATA_WIDTH   = BANK_DATA_WIDTH,
    parameter int ADDR_WIDTH   = BANK_ADDR_WIDTH,
    parameter int BYTE_OFFSET  = BANK_BYTE_OFFSET,
    parameter int MAX_RD_STALL = 4,
    parameter int RD_OUT_REG   = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_en,
    input  logic [ADDR_WIDTH+BYTE_OFFSET-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic [DATA_WIDTH/8-1:0]           wr_strb,
    output logic                              wr_grant,
    input  logic                              rd_en,
    input  logic [ADDR_WIDTH+BYTE_OFFSET-1:0] rd_addr,
    output logic                              rd_grant,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_data_valid,
    output logic                              sram_ceb,
    output logic                              sram_web,
    output logic [ADDR_WIDTH-1:0]             sram_a,
    output logic [DATA_WIDTH-1:0]             sram_d,
    output logic [DATA_WIDTH-1:0]             sram_bweb,
    input  logic [DATA_WIDTH-1:0]             sram_q
);

    localparam int STRB_W      = DATA_WIDTH / 8;
    localparam int BADDR_W     = ADDR_WIDTH + BYTE_OFFSET;
    localparam int PIPE_DEPTH  = 1 + BANK_SRAM_RD_LATENCY + RD_OUT_REG;
    localparam int CAPTURE_IDX = BANK_SRAM_RD_LATENCY;
    localparam int STALL_W     = $clog2(MAX_RD_STALL + 1);

    arb_sel_e                  sel;
    logic [STALL_W-1:0]        stall_cnt;
    logic                      stall_max;
    logic [DATA_WIDTH-1:0]     wr_bweb;
    logic [PIPE_DEPTH-1:0]     valid_pipe;
    logic [DATA_WIDTH-1:0]     rd_data_hold;
    logic                      unused_bits;

    assign stall_max = (stall_cnt == STALL_W'(MAX_RD_STALL));

    // A pending read that has already lost MAX_RD_STALL times beats a write.
    always_comb begin
        sel = ARB_IDLE;
        if (rd_en && (!wr_en || stall_max)) begin
            sel = ARB_READ;
        end else if (wr_en) begin
            sel = ARB_WRITE;
        end
    end

    assign rd_grant = (sel == ARB_READ);
    assign wr_grant = (sel == ARB_WRITE);

    always_comb begin
        wr_bweb = '1;
        for (int i = 0; i < STRB_W; i++) begin
            wr_bweb[8*i +: 8] = {8{~wr_strb[i]}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (!rd_en || rd_grant) begin
            stall_cnt <= '0;
        end else if (!stall_max) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // A granted write with no strobes is acknowledged but never reaches the SRAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_ceb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_bweb <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else begin
            sram_ceb  <= 1'b1;
            sram_web  <= 1'b1;
            sram_bweb <= '1;
            case (sel)
                ARB_WRITE: begin
                    if (|wr_strb) begin
                        sram_ceb  <= 1'b0;
                        sram_web  <= 1'b0;
                        sram_bweb <= wr_bweb;
                        sram_a    <= wr_addr[BADDR_W-1:BYTE_OFFSET];
                        sram_d    <= wr_data;
                    end
                end
                ARB_READ: begin
                    sram_ceb <= 1'b0;
                    sram_a   <= rd_addr[BADDR_W-1:BYTE_OFFSET];
                end
                default: ;
            endcase
        end
    end

    glb_valid_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_valid_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (rd_grant),
        .valid_pipe(valid_pipe)
    );

    // sram_q is valid in the cycle CAPTURE_IDX stage is set; latch it there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_hold <= '0;
        end else if (valid_pipe[CAPTURE_IDX]) begin
            rd_data_hold <= sram_q;
        end
    end

    generate
        if (RD_OUT_REG != 0) begin : g_rd_reg
            assign rd_data       = rd_data_hold;
            assign rd_data_valid = valid_pipe[PIPE_DEPTH-1];
        end else begin : g_rd_pass
            assign rd_data       = valid_pipe[CAPTURE_IDX] ? sram_q : rd_data_hold;
            assign rd_data_valid = valid_pipe[CAPTURE_IDX];
        end
    endgenerate

    assign unused_bits = ^{wr_addr[BYTE_OFFSET-1:0], rd_addr[BYTE_OFFSET-1:0], valid_pipe};

endmodule

// File: tb/tb_glb_bank_mem_ctrl.sv
// Randomised self-checking bench for glb_bank_mem_ctrl with a 2-cycle SRAM
// model and a transaction-level memory/latency reference.
module tb_glb_bank_mem_ctrl;

    localparam int DW    = 64;
    localparam int AW    = 14;
    localparam int BO    = 3;
    localparam int SW    = DW / 8;
    localparam int WORDS = 64;
    localparam int LAT   = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic             clk;
    logic             reset_n;
    logic             wr_en;
    logic [AW+BO-1:0] wr_addr;
    logic [DW-1:0]    wr_data;
    logic [SW-1:0]    wr_strb;
    logic             wr_grant;
    logic             rd_en;
    logic [AW+BO-1:0] rd_addr;
    logic             rd_grant;
    logic [DW-1:0]    rd_data;
    logic             rd_data_valid;
    logic             sram_ceb;
    logic             sram_web;
    logic [AW-1:0]    sram_a;
    logic [DW-1:0]    sram_d;
    logic [DW-1:0]    sram_bweb;
    logic [DW-1:0]    sram_q;

    int vec_count = 0;
    int err_count = 0;
    int cyc = 0;

    logic [DW-1:0] ref_mem [WORDS];
    rd_exp_t       rd_q [$];
    int            rd_wait;
    logic          exp_ceb, exp_web;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d, exp_bweb, exp_rd_data;

    glb_bank_mem_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_grant     (wr_grant),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_grant     (rd_grant),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .sram_ceb     (sram_ceb),
        .sram_web     (sram_web),
        .sram_a       (sram_a),
        .sram_d       (sram_d),
        .sram_bweb    (sram_bweb),
        .sram_q       (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM environment model: two-cycle read latency, bit-masked writes.
    logic [DW-1:0] sram_mem [WORDS];
    logic [DW-1:0] sram_s1;
    logic          mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < WORDS; i++) sram_mem[i] <= '0;
            mem_init_done <= 1'b1;
        end else if (!sram_ceb) begin
            if (!sram_web)
                sram_mem[sram_a[5:0]] <= (sram_mem[sram_a[5:0]] & sram_bweb) | (sram_d & ~sram_bweb);
            else
                sram_s1 <= sram_mem[sram_a[5:0]];
        end
        sram_q <= sram_s1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, cycle %0d expected < 20000", cyc);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s (cycle %0d): got %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    task automatic resetModel();
        rd_q.delete();
        rd_wait     = 0;
        exp_ceb     = 1'b1;
        exp_web     = 1'b1;
        exp_bweb    = '1;
        exp_a       = '0;
        exp_d       = '0;
        exp_rd_data = '0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_ceb",   {63'd0, sram_ceb}, 64'd1);
        checkOutput("rst_web",   {63'd0, sram_web}, 64'd1);
        checkOutput("rst_bweb",  sram_bweb, '1);
        checkOutput("rst_a",     {50'd0, sram_a}, 64'd0);
        checkOutput("rst_d",     sram_d, 64'd0);
        checkOutput("rst_rdata", rd_data, 64'd0);
        checkOutput("rst_valid", {63'd0, rd_data_valid}, 64'd0);
    endtask

    // One clock cycle: check registered outputs, drive requests, check grants, advance the model.
    task automatic applyStimulus(input logic we, input logic [AW+BO-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [SW-1:0] ws, input logic re, input logic [AW+BO-1:0] ra,
                                 output logic wg, output logic rg);
        logic exp_v;
        int   w;
        @(negedge clk);
        cyc++;
        checkOutput("sram_ceb",  {63'd0, sram_ceb}, {63'd0, exp_ceb});
        checkOutput("sram_web",  {63'd0, sram_web}, {63'd0, exp_web});
        checkOutput("sram_bweb", sram_bweb, exp_bweb);
        checkOutput("sram_a",    {50'd0, sram_a}, {50'd0, exp_a});
        checkOutput("sram_d",    sram_d, exp_d);
        exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        checkOutput("rd_valid",  {63'd0, rd_data_valid}, {63'd0, exp_v});
        if (exp_v) begin
            exp_rd_data = rd_q[0].data;
            void'(rd_q.pop_front());
        end
        checkOutput("rd_data",   rd_data, exp_rd_data);

        wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_en = re; rd_addr = ra;
        #1;
        rg = re && (!we || rd_wait >= 4);
        wg = we && !rg;
        checkOutput("rd_grant", {63'd0, rd_grant}, {63'd0, rg});
        checkOutput("wr_grant", {63'd0, wr_grant}, {63'd0, wg});
        rd_wait = (re && !rg) ? ((rd_wait < 4) ? rd_wait + 1 : 4) : 0;

        exp_ceb  = 1'b1;
        exp_web  = 1'b1;
        exp_bweb = '1;
        if (wg && ws != '0) begin
            w        = int'(wa >> BO);
            exp_ceb  = 1'b0;
            exp_web  = 1'b0;
            exp_a    = AW'(w);
            exp_d    = wd;
            for (int b = 0; b < SW; b++) begin
                exp_bweb[8*b +: 8] = ws[b] ? 8'h00 : 8'hFF;
                if (ws[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
        end else if (rg) begin
            w       = int'(ra >> BO);
            exp_ceb = 1'b0;
            exp_a   = AW'(w);
            rd_q.push_back('{data: ref_mem[w], due: cyc + LAT});
        end
    endtask

    task automatic idleCycles(input int n);
        logic g1, g2;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, g1, g2);
    endtask

    function automatic logic [AW+BO-1:0] byteAddr(input int word);
        byteAddr = (AW+BO)'(word * 8 + int'($urandom_range(0, 7)));
    endfunction

    initial begin
        logic wg, rg;
        logic w_pend, r_pend;
        logic [AW+BO-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        int n, pulses;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        resetModel();
        reset_n = 1'b0;
        wr_en = 0; wr_addr = '0; wr_data = '0; wr_strb = '0; rd_en = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checkResetState();
        idleCycles(2);

        // Full-word write then read of byte address 0x40.
        applyStimulus(1'b1, 17'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, '0, wg, rg);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 17'h40, wg, rg);
        idleCycles(LAT);
        checkOutput("beef_valid", {63'd0, rd_data_valid}, 64'd1);
        checkOutput("beef_data",  rd_data, 64'hDEAD_BEEF_0123_4567);

        // Partial-strobe write over word 0, then a zero-strobe write.
        applyStimulus(1'b1, 17'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0, '0, wg, rg);
        applyStimulus(1'b1, 17'h3, 64'h1234_5678_9ABC_DEF0, 8'h00, 1'b0, '0, wg, rg);
        checkOutput("strb0_grant", {63'd0, wr_grant}, 64'd1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 17'h5, wg, rg);
        idleCycles(LAT);
        checkOutput("strb_data", rd_data, 64'h0000_0000_FFFF_FFFF);

        // Read starved by continuous writes must win on its 5th cycle.
        n = 0;
        rg = 1'b0;
        while (!rg && n < 10) begin
            n++;
            applyStimulus(1'b1, byteAddr(20 + n), {$urandom, $urandom}, 8'hFF, 1'b1, byteAddr(3), wg, rg);
        end
        checkOutput("stall_cycles", 64'(n), 64'd5);
        applyStimulus(1'b1, byteAddr(30), {$urandom, $urandom}, 8'hFF, 1'b1, byteAddr(4), wg, rg);
        checkOutput("stall_clear", {63'd0, rd_grant}, 64'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, byteAddr(4), wg, rg);
        idleCycles(LAT);

        // Fill words 0..15, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, 17'(i * 8), {32'hA5A5_0000 + 32'(i), $urandom}, 8'hFF, 1'b0, '0, wg, rg);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, '0, '0, (i < 16), 17'(i * 8), wg, rg);
            if (rd_data_valid) pulses++;
        end
        checkOutput("b2b_pulses", 64'(pulses), 64'd16);

        // Write followed immediately by a read of the same word.
        applyStimulus(1'b1, byteAddr(5), 64'hCAFE_F00D_5555_AAAA, 8'hFF, 1'b0, '0, wg, rg);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, byteAddr(5), wg, rg);
        idleCycles(LAT);
        checkOutput("wr_rd_data", rd_data, 64'hCAFE_F00D_5555_AAAA);

        // Reset with two reads in flight drops them.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, byteAddr(1), wg, rg);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, byteAddr(2), wg, rg);
        @(negedge clk);
        reset_n = 1'b0;
        wr_en = 0; rd_en = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        resetModel();
        checkResetState();
        idleCycles(8);

        // Randomised traffic respecting the hold-until-grant protocol.
        w_pend = 1'b0;
        r_pend = 1'b0;
        wa = '0; ra = '0; wd = '0; ws = '0;
        for (int i = 0; i < 400; i++) begin
            if (!w_pend && ($urandom_range(0, 1) == 1)) begin
                w_pend = 1'b1;
                wa = byteAddr(int'($urandom_range(0, 15)));
                wd = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       ws = 8'h00;
                    1:       ws = 8'hFF;
                    default: ws = 8'($urandom);
                endcase
            end
            if (!r_pend && ($urandom_range(0, 2) != 0)) begin
                r_pend = 1'b1;
                ra = byteAddr(int'($urandom_range(0, 15)));
            end
            applyStimulus(w_pend, wa, wd, ws, r_pend, ra, wg, rg);
            if (wg) w_pend = 1'b0;
            if (rg) r_pend = 1'b0;
        end
        idleCycles(LAT + 2);
        checkOutput("drain_empty", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
